// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder (with one-bit full-adder Slice)
// Brief    : Bit-serial WIDTH-bit adder, one Slice evaluated per clock, LSB first.
// Revision : 1.0 - initial release
// ============================================================================

module Slice (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);
   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_opa;
   logic [WIDTH-1:0] r_opb;
   logic             r_carry;
   logic [WIDTH-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_s;
   logic             r_cout;
   logic             r_ovf;

   logic             w_slice_s;
   logic             w_slice_cout;
   logic             w_load;
   logic             w_shift;
   logic             w_last;
   logic [WIDTH-1:0] w_acc_nxt;

   Slice u_slice (
      .a    (r_opa[0]),
      .b    (r_opb[0]),
      .cin  (r_carry),
      .s    (w_slice_s),
      .cout (w_slice_cout)
   );

   // A start is only honoured outside SHIFT; requests while busy are dropped.
   assign w_load    = start && (r_state != ST_SHIFT);
   assign w_shift   = (r_state == ST_SHIFT);
   assign w_last    = w_shift && (r_cnt == c_LAST);
   assign w_acc_nxt = {w_slice_s, r_acc[WIDTH-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE:  if (start) w_state_nxt = ST_SHIFT;
         ST_SHIFT: if (w_last) w_state_nxt = ST_DONE;
         ST_DONE:  w_state_nxt = start ? ST_SHIFT : ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_opa   <= '0;
         r_opb   <= '0;
         r_carry <= 1'b0;
         r_acc   <= '0;
         r_cnt   <= '0;
      end else if (w_load) begin
         r_opa   <= a;
         r_opb   <= b;
         r_carry <= cin;
         r_acc   <= '0;
         r_cnt   <= '0;
      end else if (w_shift) begin
         r_opa   <= r_opa >> 1;
         r_opb   <= r_opb >> 1;
         r_carry <= w_slice_cout;
         r_acc   <= w_acc_nxt;
         r_cnt   <= r_cnt + 1'b1;
      end
   end

   // Result registers update only on the final bit, so they hold between results.
   // On that edge r_carry is the carry into the MSB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s    <= '0;
         r_cout <= 1'b0;
         r_ovf  <= 1'b0;
      end else if (w_last) begin
         r_s    <= w_acc_nxt;
         r_cout <= w_slice_cout;
         r_ovf  <= w_slice_cout ^ r_carry;
      end
   end

   assign busy = (r_state == ST_SHIFT);
   assign done = (r_state == ST_DONE);
   assign s    = r_s;
   assign cout = r_cout;
   assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder
// Brief    : Randomized and directed checks of serial_adder against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_serial_adder;
   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             cin = 1'b0;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             ovf;

   int               n_checks = 0;
   int               n_fail   = 0;
   logic [WIDTH-1:0] prev_s   = '0;

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .s     (s),
      .cout  (cout),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Model: plain integer addition; overflow when equal-signed operands give a differently signed sum.
   task automatic model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input logic tc,
                        output logic [WIDTH-1:0] es, output logic ec, output logic eo);
      int unsigned total;
      total = int'(ta) + int'(tb_v) + int'(tc);
      es = total[WIDTH-1:0];
      ec = total[WIDTH];
      eo = (ta[WIDTH-1] == tb_v[WIDTH-1]) && (es[WIDTH-1] != ta[WIDTH-1]);
   endtask

   // One operation from IDLE/DONE; optional random start pulses while busy must be ignored.
   task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input logic tc,
                         input bit noisy);
      logic [WIDTH-1:0] es;
      logic             ec, eo;
      model(ta, tb_v, tc, es, ec, eo);
      @(negedge clk);
      a = ta; b = tb_v; cin = tc; start = 1'b1;
      for (int k = 1; k <= WIDTH; k++) begin
         @(negedge clk);
         start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
         a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
         check("busy_shift", busy, 1);
         check("done_shift", done, 0);
         if (k == 3) check("s_hold", s, prev_s);
      end
      @(negedge clk);
      start = 1'b0;
      check("done_pulse", done, 1);
      check("busy_done", busy, 0);
      check("sum", s, es);
      check("cout", cout, ec);
      check("ovf", ovf, eo);
      prev_s = es;
   endtask

   initial begin
      logic [WIDTH-1:0] es;
      logic             ec, eo;

      #23;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_s", s, 0);
      check("rst_cout", cout, 0);
      check("rst_ovf", ovf, 0);
      @(negedge clk);
      rst = 1'b0;

      run_op(8'h3C, 8'h0F, 1'b0, 0);
      run_op(8'hFF, 8'h01, 1'b0, 0);
      run_op(8'hFF, 8'h00, 1'b1, 0);
      run_op(8'h7F, 8'h01, 1'b0, 0);
      run_op(8'h80, 8'h80, 1'b0, 0);

      // Second request at shift cycle 3 must be dropped: one done, sum of the first pair.
      @(negedge clk);
      a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
      for (int k = 1; k <= WIDTH + 10; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k == 3) begin
            start = 1'b1; a = 8'hAA; b = 8'h55;
         end
         check("ign_done", done, (k == WIDTH + 1) ? 1 : 0);
         if (k == WIDTH + 1) check("ign_sum", s, 8'h30);
      end
      prev_s = 8'h30;

      // Start held high: DONE chains straight back into SHIFT.
      @(negedge clk);
      a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
      for (int n = 1; n <= 3 * (WIDTH + 1); n++) begin
         @(negedge clk);
         check("b2b_done", done, (n % (WIDTH + 1) == 0) ? 1 : 0);
         check("b2b_busy", busy, (n % (WIDTH + 1) == 0) ? 0 : 1);
         if (n % (WIDTH + 1) == 0) check("b2b_sum", s, 8'h02);
      end
      start = 1'b0;
      prev_s = 8'h02;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 30; i++)
         run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1);

      // Asynchronous reset in the middle of an operation.
      run_op(8'h3C, 8'h0F, 1'b0, 0);
      @(negedge clk);
      a = 8'h11; b = 8'h22; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_s", s, 0);
      check("arst_cout", cout, 0);
      check("arst_ovf", ovf, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < WIDTH + 4; k++) begin
         @(negedge clk);
         check("arst_nodone", done, 0);
      end
      prev_s = '0;
      run_op(8'h01, 8'h02, 1'b0, 0);
      model(8'h01, 8'h02, 1'b0, es, ec, eo);
      check("post_rst_sum", s, es);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder controller built around a single instance of the team's one-bit full-adder module Slice.
- Latches two operands and a carry-in, then feeds Slice one bit per clock, LSB first.
- Registers Slice's sum and carry back each cycle and presents the completed word with a one-cycle done pulse.
- Low-area alternative to the full ripple-carry adder; same arithmetic result, WIDTH+1 cycles per operation.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.

Ports:
- clk    input   1      system clock, rising-edge
- rst    input   1      asynchronous, active-high reset
- start  input   1      request to begin an addition; sampled on rising clk
- a      input   WIDTH  operand A, captured when start is accepted
- b      input   WIDTH  operand B, captured when start is accepted
- cin    input   1      carry-in, captured when start is accepted
- busy   output  1      high while bits are being shifted (SHIFT state)
- done   output  1      one-cycle pulse: s/cout/ovf are valid for the new result
- s      output  WIDTH  registered sum
- cout   output  1      registered carry out of the MSB
- ovf    output  1      registered signed overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state=IDLE; all internal registers 0; busy=0, done=0, s=0, cout=0, ovf=0.
- Reset mid-operation aborts the operation. No done pulse is produced. Outputs go to 0 immediately, without waiting for a clock edge.
- Internal registers:
  - opa, opb: WIDTH-bit shift registers.
  - carry: 1-bit register.
  - acc: WIDTH-bit result shift register.
  - cnt: $clog2(WIDTH)-bit bit counter.
- Slice connections: a=opa[0], b=opb[0], cin=carry. Outputs are slice_s and slice_cout.
- States: IDLE, SHIFT, DONE. busy = (state==SHIFT). done = (state==DONE).
- IDLE: on start=1, load opa<=a, opb<=b, carry<=cin, acc<=0, cnt<=0; go to SHIFT. Otherwise stay in IDLE.
- SHIFT, every edge:
  - opa<=opa>>1, opb<=opb>>1
  - carry<=slice_cout
  - acc<={slice_s, acc[WIDTH-1:1]}
  - cnt<=cnt+1
- SHIFT, edge where cnt==WIDTH-1 (last bit):
  - s<={slice_s, acc[WIDTH-1:1]}
  - cout<=slice_cout
  - ovf<=slice_cout ^ carry
  - go to DONE
- DONE: lasts one cycle, done=1.
  - If start=1 in this cycle: load operands exactly as in IDLE and go directly to SHIFT (back-to-back operation).
  - Otherwise go to IDLE.
- Start while busy=1 is ignored. Operands and the in-progress result are unaffected.
- a, b, cin are don't-care except on the edge where start is accepted.
- Latency: start accepted at edge E0 → SHIFT occupies the cycles after edges E0..E(WIDTH-1) → done=1 in the cycle after edge E(WIDTH). That is WIDTH+1 cycles from acceptance to done.
- Throughput: one result per WIDTH+1 cycles.
- Output holding: s, cout and ovf change only on the last-bit SHIFT edge (or on reset). They hold their value indefinitely between results, including through IDLE and the next operation's SHIFT cycles.
- Arithmetic: {cout,s} = a + b + cin, modulo 2^(WIDTH+1). ovf is defined for two's-complement interpretation of a and b.
- Counter rollover is unused: cnt is reloaded to 0 on every accepted start.
- Slice has internal gate delays (about 3 ns from input to output). The clock period must be >= 10 ns.
- Scope: no internal pipelining; a single Slice instance only.

Test Plan:
- WIDTH=8, reset, then start with a=0x3C, b=0x0F, cin=0 → busy high for 8 cycles; done pulses exactly 9 cycles after start acceptance; s=0x4B, cout=0, ovf=0.
- a=0xFF, b=0x01, cin=0 → s=0x00, cout=1, ovf=0. Then a=0xFF, b=0x00, cin=1 → s=0x00, cout=1, ovf=0.
- a=0x7F, b=0x01, cin=0 → s=0x80, cout=0, ovf=1. Then a=0x80, b=0x80, cin=0 → s=0x00, cout=1, ovf=1.
- Start a=0x10, b=0x20; pulse start again at cycle 3 with a=0xAA, b=0x55 → second request ignored; s=0x30, single done pulse.
- Start held high continuously with a=0x01, b=0x01 → DONE re-enters SHIFT; done pulses every 9 cycles; s=0x02 each time; busy low only during the done cycles.
- After a completed result s=0x4B, start a=0x11, b=0x22; assert rst asynchronously mid-cycle at shift cycle 4 → busy/s/cout/ovf drop to 0 before the next edge; no done pulse; after rst release, next start a=0x01, b=0x02 → s=0x03.
